// File: rtl/ucie_sb_tx_serializer.sv
// rtl/ucie_sb_tx_serializer.sv - UCIe sideband TX serializer with gated source-synchronous SBTX_CLK
//
// Purpose: takes parallel sideband packets over valid/ready and shifts them out
// LSB-first on SBTX_DATA. Each UI is two clk cycles: SBTX_CLK low (phase A),
// then high (phase B). A quiet gap of 2*GAP_UI cycles follows every packet.
//
// Ports:
//   clk        core clock, 2x the UI rate
//   reset_n    synchronous active-low reset
//   in_valid   packet offered
//   in_data    packet, bit0 transmitted first
//   in_ready   holding register empty
//   SBTX_CLK   gated sideband clock (registered)
//   SBTX_DATA  serial data (registered), stable across each SBTX_CLK rise
//   tx_busy    FSM not in IDLE (registered)
//   pkt_done   one-cycle pulse after a packet's gap completes (registered)
module ucie_sb_tx_serializer #(
  parameter int PKT_WIDTH = 64,
  parameter int GAP_UI    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [PKT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 SBTX_CLK,
  output logic                 SBTX_DATA,
  output logic                 tx_busy,
  output logic                 pkt_done
);

  localparam int BW = $clog2(PKT_WIDTH);
  localparam int GW = $clog2(2 * GAP_UI);
  localparam logic [BW-1:0] BIT_LAST = BW'(PKT_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * GAP_UI - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 phase_q;     // 0: phase A (clock low), 1: phase B (clock high)
  logic [BW-1:0]        bit_cnt_q;
  logic [GW-1:0]        gap_cnt_q;
  logic [PKT_WIDTH-1:0] shift_q;
  logic [PKT_WIDTH-1:0] pend_q;
  logic                 pend_vld_q;
  logic                 sbtx_clk_q;
  logic                 sbtx_data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;

  assign accept    = in_valid && !pend_vld_q;
  assign in_ready  = !pend_vld_q;
  assign SBTX_CLK  = sbtx_clk_q;
  assign SBTX_DATA = sbtx_data_q;
  assign tx_busy   = busy_q;
  assign pkt_done  = done_q;

  // Outputs are computed from the next state at the same edge as the
  // transition, so phase A of bit0 is visible the cycle after the shifter loads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      sbtx_clk_q  <= 1'b0;
      sbtx_data_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A handshake only happens while pend is empty and a move only while it
      // is full, so the two never collide on the same edge.
      if (accept) begin
        pend_q     <= in_data;
        pend_vld_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          sbtx_clk_q  <= 1'b0;
          sbtx_data_q <= 1'b0;
          if (pend_vld_q) begin
            state_q     <= SHIFT;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= pend_q;
            pend_vld_q  <= 1'b0;
            sbtx_data_q <= pend_q[0];
            busy_q      <= 1'b1;
          end
        end

        SHIFT: begin
          if (!phase_q) begin
            phase_q    <= 1'b1;
            sbtx_clk_q <= 1'b1;
          end else if (bit_cnt_q == BIT_LAST) begin
            state_q     <= GAP;
            gap_cnt_q   <= '0;
            phase_q     <= 1'b0;
            sbtx_clk_q  <= 1'b0;
            sbtx_data_q <= 1'b0;
          end else begin
            phase_q     <= 1'b0;
            bit_cnt_q   <= bit_cnt_q + BW'(1);
            shift_q     <= shift_q >> 1;
            sbtx_clk_q  <= 1'b0;
            sbtx_data_q <= shift_q[1];
          end
        end

        GAP: begin
          sbtx_clk_q  <= 1'b0;
          sbtx_data_q <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            done_q <= 1'b1;
            if (pend_vld_q) begin
              // Back-to-back: next packet starts straight out of the gap.
              state_q     <= SHIFT;
              phase_q     <= 1'b0;
              bit_cnt_q   <= '0;
              shift_q     <= pend_q;
              pend_vld_q  <= 1'b0;
              sbtx_data_q <= pend_q[0];
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end

        default: begin
          state_q     <= IDLE;
          sbtx_clk_q  <= 1'b0;
          sbtx_data_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// tb/tb_ucie_sb_tx_serializer.sv - directed self-checking bench for ucie_sb_tx_serializer
module tb_ucie_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_valid2;
  logic [63:0] in_data, in_data2;
  logic        in_ready, sbclk, sbdata, tx_busy, pkt_done;
  logic        in_ready2, sbclk2, sbdata2, tx_busy2, pkt_done2;

  always #5 clk = ~clk;

  ucie_sb_tx_serializer #(.PKT_WIDTH(64), .GAP_UI(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .SBTX_CLK(sbclk), .SBTX_DATA(sbdata),
    .tx_busy(tx_busy), .pkt_done(pkt_done)
  );

  ucie_sb_tx_serializer #(.PKT_WIDTH(64), .GAP_UI(40)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .SBTX_CLK(sbclk2), .SBTX_DATA(sbdata2),
    .tx_busy(tx_busy2), .pkt_done(pkt_done2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Rising-edge / pkt_done recorder, sampled on the falling clk edge.
  int   rise_cyc[$];
  logic rise_dat[$];
  int   done_cyc[$];
  int   rise2_cyc[$];
  int   done2_cyc[$];
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  always @(negedge clk) begin
    if (sbclk && !prev1) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(sbdata);
    end
    if (sbclk2 && !prev2) rise2_cyc.push_back(cyc);
    if (pkt_done) done_cyc.push_back(cyc);
    if (pkt_done2) done2_cyc.push_back(cyc);
    prev1 = sbclk;
    prev2 = sbclk2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) step();
  endtask

  task automatic clear_mon();
    rise_cyc.delete();
    rise_dat.delete();
    done_cyc.delete();
    rise2_cyc.delete();
    done2_cyc.delete();
  endtask

  function automatic logic [63:0] rebuild(input int base);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      if (base + i < rise_dat.size()) v[i] = rise_dat[base + i];
    return v;
  endfunction

  function automatic int bad_spacing(input int first, input int last);
    int n;
    n = 0;
    for (int i = first + 1; i <= last && i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != 2) n++;
    return n;
  endfunction

  task automatic wait_done(input int n, input int limit);
    for (int i = 0; i < limit && done_cyc.size() < n; i++) step();
    chk("wait_pkt_done", 64'(done_cyc.size()), 64'(n));
  endtask

  int          t0, p0, pulses, acc_i;
  int          acc[3];
  logic [63:0] pk[3];

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_data   = '0;
    in_data2  = '0;

    // ---- reset state
    step(); step(); step();
    chk("rst_sbclk", sbclk, 0);
    chk("rst_sbdata", sbdata, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ready2", in_ready2, 1);
    reset_n = 1'b1;
    step();

    // ---- single packet, latency, gap quiet, pkt_done timing
    clear_mon();
    in_data  = 64'hA5A5_0000_FFFF_1234;
    in_valid = 1'b1;
    t0 = cyc;
    chk("single_ready_T", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("single_ready_T1", in_ready, 0);
    chk("single_busy_T1", tx_busy, 0);
    step();
    p0 = cyc;
    chk("single_phaseA_clk", sbclk, 0);
    chk("single_phaseA_dat", sbdata, 0);
    chk("single_busy_T2", tx_busy, 1);
    chk("single_ready_T2", in_ready, 1);
    step();
    chk("single_rise_T3", sbclk, 1);
    step_to(p0 + 128);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("gap_quiet_%0d", i), {62'd0, sbclk, sbdata}, 0);
      step();
    end
    chk("single_done_P192", pkt_done, 1);
    step();
    chk("single_done_pulse", pkt_done, 0);
    chk("single_busy_end", tx_busy, 0);
    chk("single_rises", 64'(rise_cyc.size()), 64);
    chk("single_first_rise", 64'(rise_cyc[0]), 64'(t0 + 3));
    chk("single_data", rebuild(0), 64'hA5A5_0000_FFFF_1234);
    chk("single_spacing", 64'(bad_spacing(0, 63)), 0);

    // ---- reset mid-SHIFT at bit 20
    clear_mon();
    in_data  = 64'hDEAD_BEEF_0123_4567;
    in_valid = 1'b1;
    t0 = cyc;
    step();
    in_valid = 1'b0;
    step_to(t0 + 2 + 40);
    chk("midrst_busy_before", tx_busy, 1);
    clear_mon();
    reset_n = 1'b0;
    step();
    chk("midrst_sbclk", sbclk, 0);
    chk("midrst_sbdata", sbdata, 0);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_ready", in_ready, 1);
    step(); step();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (pkt_done || sbclk) pulses++;
      step();
    end
    chk("midrst_quiet_after", 64'(pulses), 0);
    chk("midrst_no_done", 64'(done_cyc.size()), 0);

    // ---- back-to-back 64'h1 then MSB-only
    clear_mon();
    in_data  = 64'h1;
    in_valid = 1'b1;
    t0 = cyc;
    step();
    chk("b2b_ready_T1", in_ready, 0);
    in_data = 64'h8000_0000_0000_0000;
    step();
    chk("b2b_ready_T2", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_ready_T3", in_ready, 0);
    step_to(t0 + 193);
    chk("b2b_ready_lastgap", in_ready, 0);
    step();
    chk("b2b_ready_moved", in_ready, 1);
    wait_done(2, 600);
    chk("b2b_rises", 64'(rise_cyc.size()), 128);
    chk("b2b_spacing_p0", 64'(bad_spacing(0, 63)), 0);
    chk("b2b_spacing_p1", 64'(bad_spacing(64, 127)), 0);
    chk("b2b_gap_rise", 64'(rise_cyc[64] - rise_cyc[63]), 66);
    chk("b2b_done_period", 64'(done_cyc[1] - done_cyc[0]), 192);
    chk("b2b_data0", rebuild(0), 64'h1);
    chk("b2b_data1", rebuild(64), 64'h8000_0000_0000_0000);
    step_to(cyc + 4);

    // ---- holding full: three packets offered continuously
    clear_mon();
    pk[0] = 64'h0123_4567_89AB_CDEF;
    pk[1] = 64'hFEDC_BA98_7654_3210;
    pk[2] = 64'hCAFE_F00D_5555_AAAA;
    acc_i = 0;
    in_data  = pk[0];
    in_valid = 1'b1;
    for (int i = 0; i < 800 && acc_i < 3; i++) begin
      if (in_ready) begin
        acc[acc_i] = cyc;
        acc_i++;
      end
      step();
      if (acc_i >= 3) in_valid = 1'b0;
      else in_data = pk[acc_i];
    end
    in_valid = 1'b0;
    chk("hold_accepts", 64'(acc_i), 3);
    chk("hold_acc1", 64'(acc[1] - acc[0]), 2);
    chk("hold_acc2", 64'(acc[2] - acc[0]), 194);
    wait_done(3, 800);
    chk("hold_acc2_after_done", 64'(acc[2]), 64'(done_cyc[0]));
    chk("hold_rises", 64'(rise_cyc.size()), 192);
    chk("hold_data0", rebuild(0), pk[0]);
    chk("hold_data1", rebuild(64), pk[1]);
    chk("hold_data2", rebuild(128), pk[2]);
    chk("hold_done_period", 64'(done_cyc[2] - done_cyc[1]), 192);
    step_to(cyc + 4);

    // ---- handshake on the last GAP cycle goes through IDLE
    clear_mon();
    in_data  = 64'h0000_0000_0000_00F1;
    in_valid = 1'b1;
    t0 = cyc;
    step();
    in_valid = 1'b0;
    step_to(t0 + 2 + 191);
    chk("lastgap_ready", in_ready, 1);
    in_data  = 64'h1357_9BDF_2468_ACE0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lastgap_done", pkt_done, 1);
    chk("lastgap_idle_clk", sbclk, 0);
    wait_done(2, 600);
    chk("lastgap_rises", 64'(rise_cyc.size()), 128);
    chk("lastgap_spacing", 64'(rise_cyc[64] - rise_cyc[63]), 67);
    chk("lastgap_data0", rebuild(0), 64'h0000_0000_0000_00F1);
    chk("lastgap_data1", rebuild(64), 64'h1357_9BDF_2468_ACE0);

    // ---- GAP_UI=40 instance, back-to-back
    clear_mon();
    in_data2  = 64'h3;
    in_valid2 = 1'b1;
    step();
    in_data2 = 64'hF0;
    step();
    chk("g40_ready_T2", in_ready2, 1);
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < 700 && done2_cyc.size() < 2; i++) step();
    chk("g40_dones", 64'(done2_cyc.size()), 2);
    chk("g40_rises", 64'(rise2_cyc.size()), 128);
    chk("g40_gap_rise", 64'(rise2_cyc[64] - rise2_cyc[63]), 82);
    chk("g40_done_period", 64'(done2_cyc[1] - done2_cyc[0]), 208);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
